alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_op_check.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller:
//   DATA_W          operand / result width
//   OP_*            ALU op-code encodings (ADD, SUB, AND, OR, SLT)
//   state_t, ST_*   issue-controller FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    // Plain vector type with named constants keeps the encoding visible to
    // older tools and waveform viewers.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

endpackage : alu_pkg

// File: rtl/alu_op_check.sv
// -----------------------------------------------------------------------------
// alu_op_check
// Combinational op-code legality decode.
// Ports:
//   op       in  3  ALU op code
//   illegal  out 1  1 when op is not one of the supported encodings
// -----------------------------------------------------------------------------
module alu_op_check
    import alu_pkg::*;
(
    input  logic [2:0] op,
    output logic       illegal
);

    // Anything outside the supported op set (including future encodings) is illegal.
    always_comb begin
        illegal = 1'b1;
        case (op)
            OP_ADD:  illegal = 1'b0;
            OP_SUB:  illegal = 1'b0;
            OP_AND:  illegal = 1'b0;
            OP_OR:   illegal = 1'b0;
            OP_SLT:  illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

endmodule : alu_op_check

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issues one request at a time to an external combinational ALU and returns
// the captured result and flags through a valid/ready response channel.
//
// Flow: IDLE --accept--> DRIVE (one cycle, ALU settles) --> RESP (hold until
// rsp_ready). A new request may be accepted on the same edge the response is
// consumed, going straight back to DRIVE.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_a, req_b, req_f         operands and op code
//   req_acc                     use internal accumulator as operand a
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_negative, rsp_err
//                               captured response
//   sticky_ovf, clr_sticky      overflow-seen flag and its clear
//   alu_a, alu_b, alu_f         registered operands to the external ALU
//   alu_result, alu_zero, alu_overflow, alu_carry, alu_negative
//                               external ALU outputs
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_f,
    input  logic              req_acc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_carry,
    output logic              rsp_negative,
    output logic              rsp_err,
    output logic              sticky_ovf,
    input  logic              clr_sticky,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    input  logic              alu_negative
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              illegal_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              capture_s;
    logic              sticky_set_s;

    logic              rsp_valid_r;
    logic [DATA_W-1:0] acc_r;
    logic              op_err_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [2:0]        alu_f_r;
    logic [DATA_W-1:0] rsp_result_r;
    logic              rsp_zero_r;
    logic              rsp_overflow_r;
    logic              rsp_carry_r;
    logic              rsp_negative_r;
    logic              rsp_err_r;
    logic              sticky_ovf_r;

    alu_op_check u_op_check (
        .op      (req_f),
        .illegal (illegal_s)
    );

    // Request readiness: free in IDLE, or in RESP when the response leaves this edge.
    always_comb begin
        req_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  req_ready_s = 1'b1;
            ST_DRIVE: req_ready_s = 1'b0;
            ST_RESP:  req_ready_s = rsp_ready;
            default:  req_ready_s = 1'b0;
        endcase
    end

    assign accept_s  = req_valid & req_ready_s;
    assign capture_s = (state_r == ST_DRIVE);
    // Illegal ops never contribute to the overflow history.
    assign sticky_set_s = capture_s & ~op_err_r & alu_overflow;

    // Next-state decode; an unused encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: state_nxt_s = ST_RESP;
            ST_RESP: begin
                // accept_s in RESP implies rsp_ready, so the response leaves too.
                if (accept_s) begin
                    state_nxt_s = ST_DRIVE;
                end else if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and registered response-valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Issue registers: operands to the ALU change only on an acceptance edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_r  <= {DATA_W{1'b0}};
            alu_b_r  <= {DATA_W{1'b0}};
            alu_f_r  <= 3'b000;
            op_err_r <= 1'b0;
        end else if (accept_s) begin
            alu_a_r  <= req_acc ? acc_r : req_a;
            alu_b_r  <= req_b;
            alu_f_r  <= req_f;
            op_err_r <= illegal_s;
        end else begin
            alu_a_r  <= alu_a_r;
            alu_b_r  <= alu_b_r;
            alu_f_r  <= alu_f_r;
            op_err_r <= op_err_r;
        end
    end

    // Response capture at the closing edge of DRIVE; illegal ops get a fixed pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_result_r   <= {DATA_W{1'b0}};
            rsp_zero_r     <= 1'b0;
            rsp_overflow_r <= 1'b0;
            rsp_carry_r    <= 1'b0;
            rsp_negative_r <= 1'b0;
            rsp_err_r      <= 1'b0;
        end else if (capture_s && op_err_r) begin
            rsp_result_r   <= {DATA_W{1'b0}};
            rsp_zero_r     <= 1'b1;
            rsp_overflow_r <= 1'b0;
            rsp_carry_r    <= 1'b0;
            rsp_negative_r <= 1'b0;
            rsp_err_r      <= 1'b1;
        end else if (capture_s) begin
            rsp_result_r   <= alu_result;
            rsp_zero_r     <= alu_zero;
            rsp_overflow_r <= alu_overflow;
            rsp_carry_r    <= alu_carry;
            rsp_negative_r <= alu_negative;
            rsp_err_r      <= 1'b0;
        end else begin
            rsp_result_r   <= rsp_result_r;
            rsp_zero_r     <= rsp_zero_r;
            rsp_overflow_r <= rsp_overflow_r;
            rsp_carry_r    <= rsp_carry_r;
            rsp_negative_r <= rsp_negative_r;
            rsp_err_r      <= rsp_err_r;
        end
    end

    // Accumulator follows legal results only, so an illegal op leaves it intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (capture_s && !op_err_r) begin
            acc_r <= alu_result;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Sticky overflow; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_ovf_r <= 1'b0;
        end else if (sticky_set_s) begin
            sticky_ovf_r <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf_r <= 1'b0;
        end else begin
            sticky_ovf_r <= sticky_ovf_r;
        end
    end

    assign req_ready    = req_ready_s;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_overflow = rsp_overflow_r;
    assign rsp_carry    = rsp_carry_r;
    assign rsp_negative = rsp_negative_r;
    assign rsp_err      = rsp_err_r;
    assign sticky_ovf   = sticky_ovf_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_f        = alu_f_r;

endmodule : alu_issue_ctrl
